// File: rtl/alarm_sequencer.sv
// Arming/alarm controller: exit delay, armed, entry delay and timed alarm phases.
// Optional feature: define ALARM_BLINK_EN to pulse the siren with a BLINK_CYCLES half-period.
module alarm_sequencer #(
  parameter int                    NUM_ZONES       = 2,
  parameter logic [NUM_ZONES-1:0]  DELAY_ZONE_MASK = 2'b01,
  parameter int unsigned           EXIT_CYCLES     = 250_000_000,
  parameter int unsigned           ENTRY_CYCLES    = 250_000_000,
  parameter int unsigned           ALARM_CYCLES    = 1_500_000_000,
  parameter int unsigned           BLINK_CYCLES    = 6_250_000
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset_n,
  input  logic                 i_Arm_Req,
  input  logic                 i_Disarm_Req,
  input  logic [NUM_ZONES-1:0] i_Zone_Trip,
  output logic [2:0]           o_State,
  output logic                 o_Armed_LED,
  output logic                 o_Siren,
  output logic [NUM_ZONES-1:0] o_Alarm_Zones,
  output logic                 o_Arm_Fault
);

  typedef enum logic [2:0] {
    DISARMED    = 3'd0,
    EXIT_DELAY  = 3'd1,
    ARMED       = 3'd2,
    ENTRY_DELAY = 3'd3,
    ALARM       = 3'd4
  } state_t;

  localparam int unsigned MAX_EE     = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_EE > ALARM_CYCLES) ? MAX_EE : ALARM_CYCLES;
  localparam int          TIMER_W    = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TIMER_W-1:0] EXIT_LAST  = TIMER_W'(EXIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ENTRY_LAST = TIMER_W'(ENTRY_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ALARM_LAST = TIMER_W'(ALARM_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

  generate
    if ((NUM_ZONES < 1) || (NUM_ZONES > 8) || (EXIT_CYCLES < 2) || (ENTRY_CYCLES < 2) ||
        (ALARM_CYCLES < 2) || (BLINK_CYCLES < 1)) begin : g_bad_params
      $error("alarm_sequencer: parameter out of range");
    end
  endgenerate

  state_t                state;
  state_t                state_next;
  logic [TIMER_W-1:0]    timer;
  logic [NUM_ZONES-1:0]  zones_next;
  logic                  fault_next;
  logic [NUM_ZONES-1:0]  instant_trip;
  logic [NUM_ZONES-1:0]  delayed_trip;

  assign instant_trip = i_Zone_Trip & ~DELAY_ZONE_MASK;
  assign delayed_trip = i_Zone_Trip & DELAY_ZONE_MASK;

  always_comb begin
    state_next = state;
    zones_next = o_Alarm_Zones;
    fault_next = 1'b0;
    if (i_Disarm_Req) begin
      state_next = DISARMED;
    end else begin
      case (state)
        DISARMED: begin
          if (i_Arm_Req) begin
            if (|i_Zone_Trip) begin
              fault_next = 1'b1;
            end else begin
              state_next = EXIT_DELAY;
              zones_next = '0;
            end
          end
        end
        EXIT_DELAY: begin
          if (timer == EXIT_LAST) state_next = ARMED;
        end
        ARMED: begin
          zones_next = o_Alarm_Zones | i_Zone_Trip;
          if (|instant_trip)      state_next = ALARM;
          else if (|delayed_trip) state_next = ENTRY_DELAY;
        end
        ENTRY_DELAY: begin
          zones_next = o_Alarm_Zones | i_Zone_Trip;
          if ((|instant_trip) || (timer == ENTRY_LAST)) state_next = ALARM;
        end
        ALARM: begin
          zones_next = o_Alarm_Zones | i_Zone_Trip;
          if (timer == ALARM_LAST) state_next = ARMED;
        end
        default: state_next = DISARMED;
      endcase
    end
  end

  // Timer restarts on every state change and saturates while idling in untimed states.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state         <= DISARMED;
      timer         <= '0;
      o_Armed_LED   <= 1'b0;
      o_Alarm_Zones <= '0;
      o_Arm_Fault   <= 1'b0;
    end else begin
      state         <= state_next;
      o_Armed_LED   <= (state_next != DISARMED);
      o_Alarm_Zones <= zones_next;
      o_Arm_Fault   <= fault_next;
      if (state_next != state) timer <= '0;
      else if (timer != TIMER_MAX) timer <= timer + 1'b1;
    end
  end

  assign o_State = state;

`ifdef ALARM_BLINK_EN
  localparam int                 BLINK_W    = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt;

  // Siren starts high on ALARM entry and flips after each BLINK_CYCLES-long phase.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      o_Siren   <= 1'b0;
      blink_cnt <= '0;
    end else if (state_next != ALARM) begin
      o_Siren   <= 1'b0;
      blink_cnt <= '0;
    end else if (state != ALARM) begin
      o_Siren   <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BLINK_LAST) begin
      o_Siren   <= ~o_Siren;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) o_Siren <= 1'b0;
    else            o_Siren <= (state_next == ALARM);
  end
`endif

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: directed vectors with literal expectations
// plus a per-cycle comparison against a dwell-time behavioural model.
module tb_alarm_sequencer;

  localparam int              NZ    = 2;
  localparam logic [NZ-1:0]   MASK  = 2'b01;
  localparam int              EXIT  = 4;
  localparam int              ENTRY = 3;
  localparam int              ALRM  = 6;
  localparam int              BLINK = 2;

  logic          clk;
  logic          rst_n;
  logic          arm;
  logic          disarm;
  logic [NZ-1:0] trip;
  logic [2:0]    state;
  logic          led;
  logic          siren;
  logic [NZ-1:0] zones;
  logic          fault;

  int total;
  int bad;

  alarm_sequencer #(
    .NUM_ZONES       (NZ),
    .DELAY_ZONE_MASK (MASK),
    .EXIT_CYCLES     (EXIT),
    .ENTRY_CYCLES    (ENTRY),
    .ALARM_CYCLES    (ALRM),
    .BLINK_CYCLES    (BLINK)
  ) dut (
    .i_Clk         (clk),
    .i_Reset_n     (rst_n),
    .i_Arm_Req     (arm),
    .i_Disarm_Req  (disarm),
    .i_Zone_Trip   (trip),
    .o_State       (state),
    .o_Armed_LED   (led),
    .o_Siren       (siren),
    .o_Alarm_Zones (zones),
    .o_Arm_Fault   (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle with the given inputs; returns just after the edge.
  task automatic applyStimulus(input logic r, input logic a, input logic d, input logic [NZ-1:0] z);
    rst_n  = r;
    arm    = a;
    disarm = d;
    trip   = z;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: tracks state code and completed cycles spent in the current state.
  int            m_state;
  int            m_dwell;
  logic [NZ-1:0] m_zones;
  logic          m_fault;
  logic          m_led;
  logic          m_siren;
  bit            model_valid = 1'b0;

  always @(posedge clk) begin : model
    int nxt;
    int done;
    if (!rst_n) begin
      m_state     = 0;
      m_dwell     = 0;
      m_zones     = '0;
      m_fault     = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      nxt     = m_state;
      done    = m_dwell + 1;
      m_fault = 1'b0;
      if (disarm) nxt = 0;
      else begin
        case (m_state)
          0: if (arm) begin
               if (trip == 0) begin nxt = 1; m_zones = '0; end
               else m_fault = 1'b1;
             end
          1: if (done == EXIT) nxt = 2;
          2: begin
               m_zones = m_zones | trip;
               if ((trip & ~MASK) != 0)     nxt = 4;
               else if ((trip & MASK) != 0) nxt = 3;
             end
          3: begin
               m_zones = m_zones | trip;
               if (((trip & ~MASK) != 0) || (done == ENTRY)) nxt = 4;
             end
          4: begin
               m_zones = m_zones | trip;
               if (done == ALRM) nxt = 2;
             end
          default: nxt = 0;
        endcase
      end
      m_dwell = (nxt == m_state) ? done : 0;
      m_state = nxt;
    end
    m_led = (m_state != 0);
`ifdef ALARM_BLINK_EN
    m_siren = (m_state == 4) && (((m_dwell / BLINK) % 2) == 0);
`else
    m_siren = (m_state == 4);
`endif
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model_state", 32'(state), 32'(m_state));
      checkOutput("model_led",   32'(led),   32'(m_led));
      checkOutput("model_siren", 32'(siren), 32'(m_siren));
      checkOutput("model_zones", 32'(zones), 32'(m_zones));
      checkOutput("model_fault", 32'(fault), 32'(m_fault));
    end
  end

  logic [5:0] siren_pat;

  initial begin
    total = 0;
    bad   = 0;
`ifdef ALARM_BLINK_EN
    siren_pat = 6'b110011;
`else
    siren_pat = 6'b111111;
`endif

    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("reset_state", 32'(state), 0);
    checkOutput("reset_led",   32'(led),   0);
    checkOutput("reset_siren", 32'(siren), 0);
    checkOutput("reset_zones", 32'(zones), 0);
    checkOutput("reset_fault", 32'(fault), 0);

    // Refused arm: zone 1 open
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b10);
    checkOutput("refuse_state", 32'(state), 0);
    checkOutput("refuse_fault", 32'(fault), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    checkOutput("refuse_fault_drop", 32'(fault), 0);

    // Successful arm: four exit cycles, zones ignored during exit
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
    checkOutput("exit_c1_state", 32'(state), 1);
    checkOutput("exit_c1_led",   32'(led),   1);
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, (i == 3) ? 2'b01 : 2'b00);
      checkOutput("exit_state", 32'(state), 1);
      checkOutput("exit_led",   32'(led),   1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    checkOutput("armed_state", 32'(state), 2);
    checkOutput("armed_zones", 32'(zones), 0);

    // Delayed zone pulse: three entry cycles then six alarm cycles
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b01);
    checkOutput("entry_c1_state", 32'(state), 3);
    checkOutput("entry_zones",    32'(zones), 1);
    for (int i = 2; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
      checkOutput("entry_state", 32'(state), 3);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
      checkOutput("alarm_state", 32'(state), 4);
      checkOutput("alarm_siren", 32'(siren), 32'(siren_pat[5-i]));
      checkOutput("alarm_zones", 32'(zones), 1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    checkOutput("rearm_state", 32'(state), 2);
    checkOutput("rearm_siren", 32'(siren), 0);
    checkOutput("rearm_zones", 32'(zones), 1);

    // Arm request while armed is ignored silently
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
    checkOutput("ignored_arm_state", 32'(state), 2);
    checkOutput("ignored_arm_fault", 32'(fault), 0);

    // Instant zone on entry cycle 2 cuts the delay short
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b01);
    checkOutput("entry2_state", 32'(state), 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b10);
    checkOutput("instant_state", 32'(state), 4);
    checkOutput("instant_zones", 32'(zones), 3);
    checkOutput("instant_siren", 32'(siren), 1);

    // Arm and disarm together: disarm wins, no fault, zones kept
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00);
    checkOutput("disarm_state", 32'(state), 0);
    checkOutput("disarm_siren", 32'(siren), 0);
    checkOutput("disarm_led",   32'(led),   0);
    checkOutput("disarm_fault", 32'(fault), 0);
    checkOutput("disarm_zones", 32'(zones), 3);

    // New arm clears zones; reset during exit drops everything
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
    checkOutput("arm2_state", 32'(state), 1);
    checkOutput("arm2_zones", 32'(zones), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("midreset_state", 32'(state), 0);
    checkOutput("midreset_led",   32'(led),   0);
    checkOutput("midreset_siren", 32'(siren), 0);
    checkOutput("midreset_fault", 32'(fault), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    checkOutput("post_reset_state", 32'(state), 0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Arming/alarm controller for the security system. Consumes debounced, registered zone-trip levels and one-cycle arm/disarm request pulses from the input-conditioning stage. Sequences the system through exit delay, armed, entry delay and alarm phases using cycle-accurate timers, and drives the armed indicator, the siren and a latched record of the zones that caused the alarm. Sits between the input-state logic and the board LEDs, replacing free-running system-state decoding with timed sequencing.

## Interface
Parameters:
- NUM_ZONES, 2: number of zone-trip inputs (1..8).
- DELAY_ZONE_MASK, 2'b01: bit i set means zone i is a delayed (entry) zone; clear means instant zone.
- EXIT_CYCLES, 250_000_000: exit-delay length in cycles (10 s at 25 MHz); minimum 2.
- ENTRY_CYCLES, 250_000_000: entry-delay length in cycles; minimum 2.
- ALARM_CYCLES, 1_500_000_000: siren-active length in cycles; minimum 2.
- BLINK_CYCLES, 6_250_000: half-period of the siren pulse pattern; used only with ALARM_BLINK_EN.

Ports:
- i_Clk  in  1  system clock; all logic on the rising edge.
- i_Reset_n  in  1  synchronous, active-low reset.
- i_Arm_Req  in  1  one-cycle arm request pulse.
- i_Disarm_Req  in  1  one-cycle disarm request pulse.
- i_Zone_Trip  in  NUM_ZONES  level per zone; 1 = zone open/tripped.
- o_State  out  3  current state encoding.
- o_Armed_LED  out  1  1 in EXIT_DELAY, ARMED, ENTRY_DELAY and ALARM.
- o_Siren  out  1  siren drive.
- o_Alarm_Zones  out  NUM_ZONES  sticky record of zones tripped in ENTRY_DELAY/ARMED/ALARM.
- o_Arm_Fault  out  1  one-cycle pulse when an arm request is refused.

## Operation
- State encoding: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4. All outputs registered.
- Reset (i_Reset_n=0 on an edge): state DISARMED, timer 0, o_Armed_LED=0, o_Siren=0, o_Alarm_Zones=0, o_Arm_Fault=0. Reset mid-timer discards the timer.
- DISARMED: i_Arm_Req with i_Zone_Trip all zero -> EXIT_DELAY and clear o_Alarm_Zones. i_Arm_Req with any zone set -> stay DISARMED and pulse o_Arm_Fault. Arm requests in any other state are ignored without a fault.
- EXIT_DELAY: zones ignored. After EXIT_CYCLES cycles -> ARMED.
- ARMED: any instant-zone trip -> ALARM. Otherwise, any delayed-zone trip -> ENTRY_DELAY. Tripped bits are OR-ed into o_Alarm_Zones.
- ENTRY_DELAY: instant-zone trip -> ALARM immediately. After ENTRY_CYCLES cycles -> ALARM. Tripped bits are OR-ed into o_Alarm_Zones.
- ALARM: o_Siren active. Tripped bits are OR-ed into o_Alarm_Zones. After ALARM_CYCLES cycles -> ARMED with siren off and o_Alarm_Zones retained.
- i_Disarm_Req in any state -> DISARMED next cycle with siren off. o_Alarm_Zones is retained until the next successful arm.
- Simultaneous i_Arm_Req and i_Disarm_Req: disarm wins and no fault is raised.
- Timer: a single counter sized $clog2 of the largest of EXIT/ENTRY/ALARM_CYCLES. It is cleared on every state change, increments otherwise, and the terminal transition fires when count == N-1. The counter never wraps.

## Timing
- An input sampled at edge k produces its state and output change visible after edge k. This is a one-cycle latency with no combinational input-to-output paths.
- Each timed state lasts exactly N cycles, where N is EXIT_CYCLES, ENTRY_CYCLES or ALARM_CYCLES as applicable.
- o_Arm_Fault is high for exactly one cycle per refused request.
- o_Alarm_Zones updates in the same cycle as the state transition it causes.

## Configuration
- ALARM_BLINK_EN defined: in ALARM, o_Siren starts at 1 on entry and toggles every BLINK_CYCLES cycles, driven by a separate blink counter cleared on ALARM entry.
- ALARM_BLINK_EN undefined: o_Siren is steady 1 throughout ALARM, and neither the blink counter nor BLINK_CYCLES logic is synthesized.
- In both cases o_Siren is 0 outside ALARM.

## Test plan
Bench parameters: EXIT=4, ENTRY=3, ALARM=6, BLINK=2, NUM_ZONES=2, mask 2'b01.
- Arm with zones clear -> o_State=1 for 4 cycles, then 2, with o_Armed_LED=1 throughout.
- Arm with i_Zone_Trip=2'b10 -> state stays 0, o_Arm_Fault high for exactly 1 cycle.
- ARMED, zone0 pulse -> state 3 for 3 cycles, then 4; o_Siren=1 for 6 cycles; then state 2; o_Alarm_Zones=2'b01 throughout.
- ENTRY_DELAY, zone1 trip on its 2nd cycle -> state 4 next cycle; o_Alarm_Zones=2'b11.
- ALARM with simultaneous i_Arm_Req and i_Disarm_Req -> state 0, o_Siren=0, no o_Arm_Fault, o_Alarm_Zones retained.
- i_Reset_n low during EXIT_DELAY -> all outputs 0 next cycle. With ALARM_BLINK_EN, siren pattern in ALARM is 1,1,0,0,1,1.
